// File: rtl/dff_rr_write_arbiter_if.sv
// Bus between N write requesters and the shared-register arbiter.
// The requester side drives req/wdata/lock. The arbiter drives the grant
// pulse and the shared register view (q/qbar, owner, busy, wr_count).
interface dff_rr_write_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   lock;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [W-1:0]   qbar;
  logic [IW-1:0]  owner;
  logic           busy;
  logic [15:0]    wr_count;

  modport master (
    output req, wdata, lock,
    input  gnt, q, qbar, owner, busy, wr_count
  );

  modport slave (
    input  req, wdata, lock,
    output gnt, q, qbar, owner, busy, wr_count
  );
endinterface

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin write controller for one shared W-bit register (q/qbar pair).
// At most one requester wins per cycle. Its data lands in q on that edge,
// and it gets a one-cycle gnt pulse. A requester that was granted last cycle
// is masked for one arbitration. This keeps the handshake clean and gives
// other requesters a turn.
// Optional feature: define REG_ARB_LOCK_EN to build the LOCKED state. In that
// state the owner writes back-to-back for up to LOCK_MAX consecutive grants.
module dff_rr_write_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dff_rr_write_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0] NC = (IW+1)'(N);

`ifdef REG_ARB_LOCK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_LOCKED = 2'd2} state_t;
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LOCK_MAX_C = LCW'(LOCK_MAX);
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   q_q, qbar_q, wsel_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  owner_q, ptr_q, ptr_d, sel_d;
  logic [15:0]    wr_count_q, wr_count_d;
  logic           found_d;
  logic           busy_d;

`ifdef REG_ARB_LOCK_EN
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lock_hold;

  // The owner keeps the register while it still asks and holds lock, up to LOCK_MAX grants.
  assign lock_hold = (state_q == S_LOCKED) && bus.req[owner_q] && bus.lock[owner_q] &&
                     (lock_cnt_q < LOCK_MAX_C);
`else
  logic lock_unused;
  assign lock_unused = (^bus.lock) ^ (LOCK_MAX > 0);
`endif

  // Round-robin pick: first eligible index scanning from ptr, skipping last cycle's grantee.
  always_comb begin
    logic [N-1:0] elig;
    logic [IW:0]  idx;
    elig    = bus.req & ~gnt_q;
    idx     = '0;
    found_d = 1'b0;
    sel_d   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= NC) idx = idx - NC;
      if (!found_d && elig[idx[IW-1:0]]) begin
        found_d = 1'b1;
        sel_d   = idx[IW-1:0];
      end
    end
`ifdef REG_ARB_LOCK_EN
    if (lock_hold) begin
      found_d = 1'b1;
      sel_d   = owner_q;
    end
`endif
  end

  // Next FSM state: idle when nothing is granted, otherwise grant or lock.
  always_comb begin
    state_d = found_d ? S_GRANT : S_IDLE;
`ifdef REG_ARB_LOCK_EN
    lock_cnt_d = '0;
    if (lock_hold) begin
      state_d    = S_LOCKED;
      lock_cnt_d = lock_cnt_q + LCW'(1);
    end else if (found_d && bus.lock[sel_d]) begin
      state_d    = S_LOCKED;
      lock_cnt_d = LCW'(1);
    end
`endif
  end

  // FSM-derived output: busy whenever a grant or lock is in progress.
  always_comb begin
    busy_d = (state_q != S_IDLE);
  end

  // Write-side next values: selected data, one-hot grant, advanced pointer, saturating count.
  always_comb begin
    wsel_d = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_d == IW'(i)) wsel_d = bus.wdata[i*W +: W];
    end
    gnt_d = '0;
    if (found_d) gnt_d[sel_d] = 1'b1;
    ptr_d      = (sel_d == IW'(N-1)) ? '0 : sel_d + IW'(1);
    wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
  end

  // FSM state register (plus lock run length when the lock feature is built).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
`ifdef REG_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef REG_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Shared register bank and arbitration bookkeeping; everything holds when nobody wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= '0;
      qbar_q     <= '1;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      wr_count_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      if (found_d) begin
        q_q        <= wsel_d;
        qbar_q     <= ~wsel_d;
        owner_q    <= sel_d;
        ptr_q      <= ptr_d;
        wr_count_q <= wr_count_d;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.q        = q_q;
  assign bus.qbar     = qbar_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_d;
  assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_dff_rr_write_arbiter.sv
module tb_dff_rr_write_arbiter;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rst;

  dff_rr_write_arbiter_if #(.N(N), .W(W)) bus ();

  dff_rr_write_arbiter #(.N(N), .W(W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state, kept as plain integers.
  int m_ptr, m_last, m_owner, m_cnt, m_q, m_lcnt, m_gnt;
  bit m_locked, m_busy;
  logic [W-1:0] dat [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_owner = 0; m_cnt = 0; m_q = 0;
    m_lcnt = 0; m_locked = 0; m_busy = 0; m_gnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},   32'(bus.gnt),      32'(m_gnt));
    chk({tag, ".q"},     32'(bus.q),        32'(m_q));
    chk({tag, ".qbar"},  32'(bus.qbar),     32'(~m_q & ((1 << W) - 1)));
    chk({tag, ".owner"}, 32'(bus.owner),    32'(m_owner));
    chk({tag, ".busy"},  32'(bus.busy),     32'(m_busy));
    chk({tag, ".count"}, 32'(bus.wr_count), 32'(m_cnt));
  endtask

  // Apply one cycle of inputs, advance the model by the arbitration rules, and compare.
  task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] l);
    int sel;
    int idx;
    sel = -1;
    bus.req  = r;
    bus.lock = l;
    for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = dat[i];
`ifdef REG_ARB_LOCK_EN
    if (m_locked && r[m_owner] && l[m_owner] && m_lcnt < LOCK_MAX) begin
      sel = m_owner;
      m_lcnt++;
    end
`endif
    if (sel < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (sel < 0 && r[idx] && idx != m_last) sel = idx;
      end
      m_locked = 0;
      m_lcnt   = 0;
`ifdef REG_ARB_LOCK_EN
      if (sel >= 0 && l[sel]) begin
        m_locked = 1;
        m_lcnt   = 1;
      end
`endif
    end
    if (sel >= 0) begin
      m_q     = int'(dat[sel]);
      m_owner = sel;
      m_ptr   = (sel + 1) % N;
      if (m_cnt < 65535) m_cnt++;
      m_gnt   = 1 << sel;
    end else begin
      m_gnt = 0;
    end
    m_last = sel;
    m_busy = (sel >= 0);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rstpulse.q",     32'(bus.q),        32'h00);
    chk("rstpulse.qbar",  32'(bus.qbar),     32'hFF);
    chk("rstpulse.gnt",   32'(bus.gnt),      32'h0);
    chk("rstpulse.owner", 32'(bus.owner),    32'h0);
    chk("rstpulse.busy",  32'(bus.busy),     32'h0);
    chk("rstpulse.count", 32'(bus.wr_count), 32'h0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  logic [N-1:0] exp_g [5];
  logic [W-1:0] exp_q [5];

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Reset held while every requester asks
    rst = 1'b1;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    bus.req = 4'b1111; bus.lock = '0;
    for (int i = 0; i < N; i++) bus.wdata[i*W +: W] = dat[i];
    @(posedge clk); @(posedge clk); #1;
    chk("reset.q",     32'(bus.q),        32'h00);
    chk("reset.qbar",  32'(bus.qbar),     32'hFF);
    chk("reset.gnt",   32'(bus.gnt),      32'h0);
    chk("reset.owner", 32'(bus.owner),    32'h0);
    chk("reset.busy",  32'(bus.busy),     32'h0);
    chk("reset.count", 32'(bus.wr_count), 32'h0);
    rst = 1'b0;
    model_reset();

    // Full contention: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      step("contend", 4'b1111, 4'b0000);
      chk("contend.gnt_seq", 32'(bus.gnt), 32'(exp_g[i]));
      chk("contend.q_seq",   32'(bus.q),   32'(exp_q[i]));
    end
    // Continue to a grant on 3, then only 0 and 3 ask
    for (int i = 0; i < 3; i++) step("contend2", 4'b1111, 4'b0000);
    chk("wrap.pre", 32'(bus.gnt), 32'h8);
    step("wrap", 4'b1001, 4'b0000);
    chk("wrap.first", 32'(bus.gnt), 32'h1);
    step("wrap", 4'b1001, 4'b0000);
    chk("wrap.second", 32'(bus.gnt), 32'h8);

    // Asynchronous reset in the middle of a burst
    step("burst", 4'b1111, 4'b0000);
    step("burst", 4'b1111, 4'b0000);
    pulse_reset();
    step("after_rst", 4'b1111, 4'b0000);
    chk("after_rst.first", 32'(bus.gnt), 32'h1);

    // Single continuous requester gets every other cycle
    pulse_reset();
    dat[2] = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      step("single", 4'b0100, 4'b0000);
      chk("single.alt", 32'(bus.gnt), (i % 2 == 0) ? 32'h4 : 32'h0);
    end
    chk("single.q",     32'(bus.q),        32'hA5);
    chk("single.qbar",  32'(bus.qbar),     32'h5A);
    chk("single.owner", 32'(bus.owner),    32'h2);
    chk("single.count", 32'(bus.wr_count), 32'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) dat[i] = W'($urandom_range(0, 255));
      step("rand", N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
    end

`ifdef REG_ARB_LOCK_EN
    // Locked owner writes back-to-back, then is forced out after LOCK_MAX grants
    pulse_reset();
    for (int i = 0; i < LOCK_MAX; i++) begin
      step("lock", 4'b0011, 4'b0001);
      chk("lock.owner_run", 32'(bus.gnt), 32'h1);
    end
    step("lock", 4'b0011, 4'b0001);
    chk("lock.forced_exit", 32'(bus.gnt), 32'h2);
    step("lock", 4'b0011, 4'b0001);
    chk("lock.resume", 32'(bus.gnt), 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
